// File: rtl/mure_pkg.sv
// Shared widths, descriptor bundle and expander state for trace block expansion.
// Consumed by itrace_block_expander.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 3;
  localparam int ITYPE_LEN   = 4;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    EMIT
  } exp_state_e;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } block_desc_s;

  function automatic logic is_compressed(input logic [31:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/itrace_block_expander.sv
// Re-expands trace block descriptors into one instruction per beat via imem refetch.
// ITRACE_LASTSIZE_CHECK_EN: flag last-instruction size mismatch on err_o.
module itrace_block_expander
  import mure_pkg::*;
#(
  parameter int FETCH_LEN = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [IRETIRE_LEN-1:0] iretire_i,
  input  logic                   ilastsize_i,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [PRIV_LEN-1:0]    priv_i,
  input  logic [XLEN-1:0]        iaddr_i,
  output logic                   imem_req_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [FETCH_LEN-1:0]   imem_rdata_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   inst_valid_o,
  output logic [XLEN-1:0]        pc_o,
  output logic [31:0]            inst_data_o,
  output logic                   compressed_o,
  output logic                   last_o,
  output logic [ITYPE_LEN-1:0]   itype_o,
  output logic [CAUSE_LEN-1:0]   cause_o,
  output logic [XLEN-1:0]        tval_o,
  output logic [PRIV_LEN-1:0]    priv_o,
  output logic                   err_o
);

  exp_state_e  state_q, state_d;
  block_desc_s desc_q, desc_d;
  logic        ready_q, ready_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        ivld_q, ivld_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        comp_q, comp_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic                   size32;
  logic                   uflow;
  logic [IRETIRE_LEN-1:0] rem_nxt;

  // desc_q.iaddr doubles as the running pc, desc_q.iretire as the remainder
  assign size32  = !is_compressed(imem_rdata_i);
  assign uflow   = size32 && (desc_q.iretire == IRETIRE_LEN'(1));
  assign rem_nxt = uflow ? '0 :
    desc_q.iretire - (size32 ? IRETIRE_LEN'(2) : IRETIRE_LEN'(1));

`ifndef ITRACE_LASTSIZE_CHECK_EN
  logic unused_lastsize;
  assign unused_lastsize = desc_q.ilastsize;
`endif

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    req_d   = req_q;
    valid_d = valid_q;
    ivld_d  = ivld_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    comp_d  = comp_q;
    last_d  = last_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          desc_d.iaddr     = iaddr_i;
          desc_d.iretire   = iretire_i;
          desc_d.ilastsize = ilastsize_i;
          desc_d.itype     = itype_i;
          desc_d.cause     = cause_i;
          desc_d.tval      = tval_i;
          desc_d.priv      = priv_i;
          if (iretire_i != '0) begin
            state_d = REQ;
            req_d   = 1'b1;
          end else begin
            state_d = EMIT;
            valid_d = 1'b1;
            ivld_d  = 1'b0;
            last_d  = 1'b1;
            pc_d    = '0;
            inst_d  = '0;
            comp_d  = 1'b0;
          end
        end
      end
      REQ: begin
        if (imem_gnt_i) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d        = EMIT;
          valid_d        = 1'b1;
          ivld_d         = 1'b1;
          pc_d           = desc_q.iaddr;
          comp_d         = !size32;
          inst_d         = size32 ? imem_rdata_i :
                           {16'h0, imem_rdata_i[15:0]};
          desc_d.iretire = rem_nxt;
          desc_d.iaddr   = desc_q.iaddr +
                           (size32 ? XLEN'(4) : XLEN'(2));
          last_d         = (rem_nxt == '0);
          err_d          = uflow;
`ifdef ITRACE_LASTSIZE_CHECK_EN
          if ((rem_nxt == '0) && (size32 != desc_q.ilastsize))
            err_d = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ivld_d  = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      desc_q  <= '0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      ivld_q  <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      comp_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      ivld_q  <= ivld_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      comp_q  <= comp_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign ready_o      = ready_q;
  assign imem_req_o   = req_q;
  assign imem_addr_o  = desc_q.iaddr;
  assign valid_o      = valid_q;
  assign inst_valid_o = ivld_q;
  assign pc_o         = pc_q;
  assign inst_data_o  = inst_q;
  assign compressed_o = comp_q;
  assign last_o       = last_q;
  assign err_o        = err_q;
  assign itype_o      = last_q ? desc_q.itype : '0;
  assign cause_o      = last_q ? desc_q.cause : '0;
  assign tval_o       = last_q ? desc_q.tval  : '0;
  assign priv_o       = last_q ? desc_q.priv  : '0;

endmodule

// File: tb/tb_itrace_block_expander.sv
// Randomized bench for itrace_block_expander against a walk-the-block model.
// Honours ITRACE_LASTSIZE_CHECK_EN in its expectations.
module tb_itrace_block_expander;
  import mure_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   valid_i;
  logic                   ready_o;
  logic [IRETIRE_LEN-1:0] iretire_i;
  logic                   ilastsize_i;
  logic [ITYPE_LEN-1:0]   itype_i;
  logic [CAUSE_LEN-1:0]   cause_i;
  logic [XLEN-1:0]        tval_i;
  logic [PRIV_LEN-1:0]    priv_i;
  logic [XLEN-1:0]        iaddr_i;
  logic                   imem_req_o;
  logic [XLEN-1:0]        imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [31:0]            imem_rdata_i;
  logic                   valid_o;
  logic                   ready_i;
  logic                   inst_valid_o;
  logic [XLEN-1:0]        pc_o;
  logic [31:0]            inst_data_o;
  logic                   compressed_o;
  logic                   last_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;
  logic                   err_o;

  itrace_block_expander #(.FETCH_LEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
    .itype_i(itype_i), .cause_i(cause_i),
    .tval_i(tval_i), .priv_i(priv_i), .iaddr_i(iaddr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .inst_valid_o(inst_valid_o), .pc_o(pc_o),
    .inst_data_o(inst_data_o), .compressed_o(compressed_o),
    .last_o(last_o), .itype_o(itype_o), .cause_o(cause_o),
    .tval_o(tval_o), .priv_o(priv_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic                 comp;
    logic                 last;
    logic                 ivld;
    logic                 err;
    logic [ITYPE_LEN-1:0] itype;
    logic [CAUSE_LEN-1:0] cause;
    logic [31:0]          tval;
    logic [PRIV_LEN-1:0]  priv;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] memh[logic [31:0]];
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_force = 0;
  int          hs_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] rd(input logic [31:0] a);
    if (memh.exists(a)) return memh[a];
    return 16'h0001;
  endfunction

  task automatic put32(input logic [31:0] a, input logic [31:0] v);
    memh[a]      = v[15:0];
    memh[a + 2]  = v[31:16];
  endtask

  // Walk the block a halfword count at a time, sizing from the low opcode bits
  task automatic model(input logic [31:0] ia, input int ir,
                       input logic ils, input logic [ITYPE_LEN-1:0] ity,
                       input logic [CAUSE_LEN-1:0] cau,
                       input logic [31:0] tv, input logic [PRIV_LEN-1:0] pr);
    beat_t       b;
    int          rem;
    int          n;
    logic [31:0] pc;
    logic [15:0] lo;
    logic [15:0] hi;
    b.itype = ity; b.cause = cau; b.tval = tv; b.priv = pr;
    if (ir == 0) begin
      b.ivld = 0; b.last = 1; b.err = 0;
      b.pc = 0; b.inst = 0; b.comp = 0;
      exp_q.push_back(b);
      return;
    end
    rem = ir;
    pc  = ia;
    while (rem > 0) begin
      lo     = rd(pc);
      hi     = rd(pc + 32'd2);
      n      = (lo[1:0] == 2'b11) ? 2 : 1;
      b.err  = (n > rem);
      rem    = b.err ? 0 : rem - n;
      b.ivld = 1;
      b.pc   = pc;
      b.comp = (n == 1);
      b.inst = (n == 2) ? {hi, lo} : {16'h0, lo};
      b.last = (rem == 0);
`ifdef ITRACE_LASTSIZE_CHECK_EN
      if (b.last && ((n == 2) != ils)) b.err = 1;
`endif
      exp_q.push_back(b);
      pc = pc + 32'(2 * n);
    end
  endtask

  // imem responder: random grant, 1..3 cycle read latency
  initial begin
    logic        req_prev;
    logic [31:0] addr_prev;
    logic        pend;
    logic [31:0] paddr;
    int          dly;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    req_prev = 0; addr_prev = 0; pend = 0; paddr = 0; dly = 0;
    forever begin
      @(negedge clk_i);
      imem_rvalid_i = 0;
      if (imem_gnt_i && req_prev) begin
        pend  = 1;
        paddr = addr_prev;
        dly   = $urandom_range(2);
        hs_cnt++;
      end
      if (pend) begin
        if (dly == 0) begin
          imem_rvalid_i = 1;
          imem_rdata_i  = {rd(paddr + 32'd2), rd(paddr)};
          pend = 0;
        end else dly--;
      end
      req_prev   = imem_req_o;
      addr_prev  = imem_addr_o;
      imem_gnt_i = imem_req_o && ($urandom_range(1) == 1);
    end
  end

  // consumer / output monitor
  initial begin
    logic        new_beat;
    logic        have;
    logic        rdy;
    logic [63:0] snap_a;
    logic [63:0] snap_b;
    beat_t       e;
    new_beat = 1; have = 0; snap_a = 0; snap_b = 0;
    ready_i = 0;
    forever begin
      @(negedge clk_i);
      if (!valid_o) begin
        if (err_o) chk("err_idle", err_o, 0);
        new_beat = 1;
        have = 0;
        ready_i = ($urandom_range(1) == 1);
      end else begin
        if (new_beat) begin
          have = (exp_q.size() != 0);
          chk("beat_expected", have, 1);
          if (have) begin
            e = exp_q[0];
            chk("inst_valid", inst_valid_o, e.ivld);
            chk("last", last_o, e.last);
            chk("err", err_o, e.err);
            if (e.ivld) begin
              chk("pc", pc_o, e.pc);
              chk("inst", inst_data_o, e.inst);
              chk("compressed", compressed_o, e.comp);
            end
            if (e.last) begin
              chk("itype", itype_o, e.itype);
              chk("cause", cause_o, e.cause);
              chk("tval", tval_o, e.tval);
              chk("priv", priv_o, e.priv);
            end
          end
          snap_a = {pc_o, inst_data_o};
          snap_b = {18'h0, tval_o, itype_o, cause_o, priv_o,
                    compressed_o, last_o, inst_valid_o};
        end else begin
          chk("stall_data", {pc_o, inst_data_o}, snap_a);
          chk("stall_ctl", {18'h0, tval_o, itype_o, cause_o, priv_o,
                            compressed_o, last_o, inst_valid_o}, snap_b);
          chk("stall_req", imem_req_o, 0);
          chk("stall_err", err_o, 0);
        end
        if (stall_force > 0) begin
          rdy = 0;
          stall_force--;
        end else rdy = ($urandom_range(3) != 0);
        ready_i = rdy;
        if (rdy) begin
          if (have) void'(exp_q.pop_front());
          have = 0;
          new_beat = 1;
        end else new_beat = 0;
      end
    end
  end

  task automatic drive(input logic [31:0] ia, input int ir, input logic ils,
                       input logic [ITYPE_LEN-1:0] ity,
                       input logic [CAUSE_LEN-1:0] cau,
                       input logic [31:0] tv, input logic [PRIV_LEN-1:0] pr);
    int t;
    model(ia, ir, ils, ity, cau, tv, pr);
    t = 0;
    while (!ready_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (!ready_o) chk("accept_timeout", ready_o, 1);
    iaddr_i = ia; iretire_i = IRETIRE_LEN'(ir); ilastsize_i = ils;
    itype_i = ity; cause_i = cau; tval_i = tv; priv_i = pr;
    valid_i = 1;
    @(negedge clk_i);
    valid_i = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && ready_o && !valid_o) && t < 500) begin
      @(negedge clk_i);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic blk(input logic [31:0] ia, input int ir, input logic ils,
                     input logic [ITYPE_LEN-1:0] ity,
                     input logic [CAUSE_LEN-1:0] cau,
                     input logic [31:0] tv, input logic [PRIV_LEN-1:0] pr);
    drive(ia, ir, ils, ity, cau, tv, pr);
    wait_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          t;
    int          h0;
    logic [31:0] ia;
    logic [15:0] hw;
    rst_ni = 0; valid_i = 0; iretire_i = 0; ilastsize_i = 0;
    itype_i = 0; cause_i = 0; tval_i = 0; priv_i = 0; iaddr_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_req", imem_req_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_pc", pc_o, 0);
    rst_ni = 1;
    @(negedge clk_i);
    chk("ready_after_rst", ready_o, 1);

    put32(32'h1000, 32'h00a00093);
    put32(32'h1004, 32'h00b10113);
    blk(32'h1000, 4, 1, 4'd0, 5'd0, 32'h0, 2'd3);

    memh[32'h2000] = 16'h4501;
    put32(32'h2002, 32'h00c18193);
    blk(32'h2000, 3, 1, 4'd2, 5'd0, 32'h0, 2'd0);

    blk(32'h0, 0, 0, 4'd1, 5'd2, 32'hdead_beef, 2'd1);

    put32(32'h3000, 32'h00d20213);
    blk(32'h3000, 1, 0, 4'd0, 5'd0, 32'h0, 2'd3);

    stall_force = 5;
    put32(32'h1000, 32'h00a00093);
    put32(32'h1004, 32'h00b10113);
    blk(32'h1000, 4, 1, 4'd3, 5'd7, 32'h1234, 2'd2);

    memh[32'h4000] = 16'h4505;
    memh[32'h4002] = 16'h0509;
    blk(32'h4000, 2, 1, 4'd0, 5'd0, 32'h0, 2'd3);

    put32(32'h5000, 32'h00a00093);
    put32(32'h5004, 32'h00a00093);
    put32(32'h5008, 32'h00a00093);
    memh[32'h500c] = 16'h8082;
    blk(32'h5000, 7, 0, 4'd5, 5'd1, 32'h5000, 2'd3);

    put32(32'hffff_fffc, 32'h00a00093);
    put32(32'h0, 32'h00b10113);
    blk(32'hffff_fffc, 4, 1, 4'd0, 5'd0, 32'h0, 2'd0);

    // reset while a read is in flight; its rvalid lands during reset
    put32(32'h6000, 32'h00a00093);
    put32(32'h6004, 32'h00a00093);
    h0 = hs_cnt;
    drive(32'h6000, 4, 1, 4'd0, 5'd0, 32'h0, 2'd0);
    t = 0;
    while (hs_cnt == h0 && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk("wait_reached", hs_cnt != h0, 1);
    rst_ni = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("mid_rst_valid", valid_o, 0);
      chk("mid_rst_ready", ready_o, 0);
      chk("mid_rst_req", imem_req_o, 0);
    end
    rst_ni = 1;
    @(negedge clk_i);
    chk("post_rst_ready", ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("post_rst_quiet", {valid_o, imem_req_o, err_o}, 0);
    end
    blk(32'h1000, 4, 1, 4'd0, 5'd0, 32'h0, 2'd3);

    for (int n = 0; n < 40; n++) begin
      ia = {17'h0, 15'($urandom_range(32767)) & 15'h7ffe} + 32'h8000;
      for (int k = 0; k < 10; k++) begin
        hw = 16'($urandom);
        if ($urandom_range(1) == 1) hw[1:0] = 2'b11;
        else if (hw[1:0] == 2'b11) hw[1:0] = 2'b01;
        memh[ia + 32'(2 * k)] = hw;
      end
      blk(ia, $urandom_range(7), 1'($urandom_range(1)),
          4'($urandom), 5'($urandom), 32'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
